// File: rtl/ysyx_22050550_alu_arb.sv
// Round-robin arbiter sharing one ALU between two requesters,
// with a single-entry registered valid/ready result stage.

module ysyx_22050550_alu #(
    parameter int len = 4
) (
    input  logic [len-1:0] a,
    input  logic [len-1:0] b,
    input  logic [2:0]     func,
    output logic [len-1:0] out,
    output logic           overflowo,
    output logic           carryo
);

    logic [len-1:0] bx;
    logic [len:0]   sum;
    logic           lt;
    logic           eq;

    // Shared adder: b is inverted and cin set for odd funcs (sub path)
    always_comb begin
        bx        = b ^ {len{func[0]}};
        sum       = {1'b0, a} + {1'b0, bx} + {{len{1'b0}}, func[0]};
        carryo    = sum[len];
        overflowo = (a[len-1] == bx[len-1]) & (sum[len-1] != a[len-1]);
        lt        = $signed(a) < $signed(b);
        eq        = (a == b);
        unique case (func)
            3'b000:  out = sum[len-1:0];
            3'b001:  out = sum[len-1:0];
            3'b010:  out = ~a;
            3'b011:  out = a & b;
            3'b100:  out = a | b;
            3'b101:  out = a ^ b;
            3'b110:  out = {{(len-1){1'b0}}, lt};
            3'b111:  out = {{(len-1){1'b0}}, eq};
            default: out = '0;
        endcase
    end

endmodule

module ysyx_22050550_alu_arb #(
    parameter int len = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [len-1:0] req0_a,
    input  logic [len-1:0] req0_b,
    input  logic [2:0]     req0_func,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [len-1:0] req1_a,
    input  logic [len-1:0] req1_b,
    input  logic [2:0]     req1_func,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [len-1:0] res_data,
    output logic           res_overflow,
    output logic           res_carry,
    output logic           res_src
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    logic           rr_ptr;
    logic           can_accept;
    logic           gnt0;
    logic           gnt1;
    logic           fire;
    logic [len-1:0] alu_a;
    logic [len-1:0] alu_b;
    logic [2:0]     alu_func;
    logic [len-1:0] alu_out;
    logic           alu_ovf;
    logic           alu_carry;

    // Grant selection; ties go to rr_ptr, ready only for the winner
    always_comb begin
        can_accept = (state == EMPTY) | res_ready;
        gnt0       = req0_valid & (~req1_valid | ~rr_ptr);
        gnt1       = req1_valid & (~req0_valid | rr_ptr);
        req0_ready = ~rst & can_accept & gnt0;
        req1_ready = ~rst & can_accept & gnt1;
        fire       = req0_ready | req1_ready;
    end

    // Operand mux: req1 only when granted, otherwise req0 passes through
    always_comb begin
        alu_a    = gnt1 ? req1_a    : req0_a;
        alu_b    = gnt1 ? req1_b    : req0_b;
        alu_func = gnt1 ? req1_func : req0_func;
    end

    ysyx_22050550_alu #(
        .len(len)
    ) u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .func      (alu_func),
        .out       (alu_out),
        .overflowo (alu_ovf),
        .carryo    (alu_carry)
    );

    assign res_valid = (state == FULL);

    // Result stage: load on fire, drain on consume, hold when stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            rr_ptr       <= 1'b0;
            res_data     <= '0;
            res_overflow <= 1'b0;
            res_carry    <= 1'b0;
            res_src      <= 1'b0;
        end else if (fire) begin
            state        <= FULL;
            rr_ptr       <= ~gnt1;
            res_data     <= alu_out;
            res_overflow <= alu_ovf;
            res_carry    <= alu_carry;
            res_src      <= gnt1;
        end else if (state == FULL && res_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_ysyx_22050550_alu_arb.sv
// Scoreboard bench for the two-port ALU arbiter (len=4).
// Directed vectors carry hand-computed {ovf,carry,data}.

module tb_ysyx_22050550_alu_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic [2:0] req0_func;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic [2:0] req1_func;
    logic       res_valid, res_ready;
    logic [3:0] res_data;
    logic       res_overflow, res_carry, res_src;

    int errors = 0;
    int checks = 0;

    logic [6:0] sb[$];
    logic [5:0] exp0, exp1;
    logic       m_full = 1'b0;
    logic       m_rr   = 1'b0;

    always #5 clk = ~clk;

    ysyx_22050550_alu_arb #(.len(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_func    (req0_func),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_func    (req1_func),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_overflow (res_overflow),
        .res_carry    (res_carry),
        .res_src      (res_src)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: compare every consumed result against the scoreboard
    always @(negedge clk) begin
        if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected: got %0h expected none",
                         {res_src, res_overflow, res_carry, res_data});
            end else begin
                chk("res", {25'd0, res_src, res_overflow, res_carry,
                            res_data}, {25'd0, sb.pop_front()});
            end
        end
    end

    // One clock of stimulus: predict grants, push expected result
    task automatic cycle();
        logic can, g0, g1, e0, e1;
        @(negedge clk);
        can = ~m_full | res_ready;
        g0  = req0_valid & (~req1_valid | ~m_rr);
        g1  = req1_valid & (~req0_valid | m_rr);
        e0  = ~rst & can & g0;
        e1  = ~rst & can & g1;
        chk("ready0", {31'd0, req0_ready}, {31'd0, e0});
        chk("ready1", {31'd0, req1_ready}, {31'd0, e1});
        chk("valid", {31'd0, res_valid}, {31'd0, m_full});
        if (e0) sb.push_back({1'b0, exp0});
        else if (e1) sb.push_back({1'b1, exp1});
        @(posedge clk);
        if (rst) begin
            m_full = 1'b0;
            m_rr   = 1'b0;
            sb.delete();
        end else if (e0 | e1) begin
            m_full = 1'b1;
            m_rr   = e0;
        end else if (m_full & res_ready) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic set0(logic [3:0] a, logic [3:0] b, logic [2:0] f,
                        logic [5:0] e);
        req0_valid = 1'b1;
        req0_a = a; req0_b = b; req0_func = f; exp0 = e;
    endtask

    task automatic set1(logic [3:0] a, logic [3:0] b, logic [2:0] f,
                        logic [5:0] e);
        req1_valid = 1'b1;
        req1_a = a; req1_b = b; req1_func = f; exp1 = e;
    endtask

    task automatic chk_res(string n, logic [6:0] e);
        chk(n, {25'd0, res_src, res_overflow, res_carry, res_data},
            {25'd0, e});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        res_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_func = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_func = '0;
        exp0 = '0; exp1 = '0;
        cycle();
        cycle();
        chk_res("reset_regs", 7'd0);
        rst = 1'b0;

        // add, overflow, carry on req0
        set0(4'h3, 4'h4, 3'b000, {2'b00, 4'h7});
        cycle();
        set0(4'h7, 4'h1, 3'b000, {2'b10, 4'h8});
        cycle();
        set0(4'hF, 4'h1, 3'b000, {2'b01, 4'h0});
        cycle();
        req0_valid = 1'b0;
        cycle();

        // compares on req1 (leaves rr_ptr at 0)
        set1(4'hE, 4'h1, 3'b110, {2'b00, 4'h1});
        cycle();
        set1(4'h5, 4'h5, 3'b111, {2'b01, 4'h1});
        cycle();
        set1(4'h5, 4'hB, 3'b110, {2'b01, 4'h0});
        cycle();
        req1_valid = 1'b0;
        cycle();

        // round-robin ties: expect 0,1,0,1
        set0(4'h2, 4'h3, 3'b001, {2'b00, 4'hF});
        set1(4'h9, 4'h5, 3'b011, {2'b11, 4'h1});
        repeat (4) cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle();

        // backpressure with both valid, then drain+refill
        set0(4'h6, 4'h3, 3'b100, {2'b10, 4'h7});
        set1(4'hC, 4'h0, 3'b010, {2'b00, 4'h3});
        cycle();
        res_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk_res("stall_hold", {1'b0, 2'b10, 4'h7});
        end
        res_ready = 1'b1;
        cycle();
        chk_res("refill", {1'b1, 2'b00, 4'h3});

        // reset during full with a pending fire
        rst = 1'b1;
        cycle();
        chk_res("rst_clear", 7'd0);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b0;
        cycle();
        set0(4'h3, 4'h4, 3'b000, {2'b00, 4'h7});
        set1(4'hC, 4'h0, 3'b010, {2'b00, 4'h3});
        res_ready = 1'b1;
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle();
        cycle();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
